// File: rtl/irq_controller.sv
// irq_controller: machine-mode interrupt arbiter with req/ack/mret handshake toward the trap logic.
// Define MTIMER_EN to build the internal mtime/mtimecmp timer; otherwise MTIP comes from timer_irq_i.
module irq_controller #(
    parameter int EXT_SRC_N = 8,
    parameter int TICK_DIV  = 1,
    localparam int CLAIM_W  = (EXT_SRC_N > 1) ? $clog2(EXT_SRC_N) : 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [EXT_SRC_N-1:0] ext_irq_i,
    input  logic [EXT_SRC_N-1:0] ext_en_i,
    input  logic                 sw_irq_i,
    input  logic                 timer_irq_i,
    input  logic                 mstatus_mie_i,
    input  logic [31:0]          mie_i,
    input  logic [1:0]           priv_i,
    input  logic                 irq_ack_i,
    input  logic                 mret_i,
    input  logic                 tcmp_we_i,
    input  logic                 tcmp_hi_i,
    input  logic [31:0]          tcmp_data_i,
    output logic                 irq_req_o,
    output logic [4:0]           irq_cause_o,
    output logic [31:0]          mip_o,
    output logic [CLAIM_W-1:0]   ext_claim_id_o,
    output logic [63:0]          mtime_o
);

    localparam logic [1:0] PRIV_MACHINE = 2'b11;
    localparam logic [4:0] CAUSE_MSI    = 5'd3;
    localparam logic [4:0] CAUSE_MTI    = 5'd7;
    localparam logic [4:0] CAUSE_MEI    = 5'd11;

    typedef enum logic [1:0] {IDLE, REQ, TRAP} state_e;

    state_e               state_reg, state_next;
    logic                 req_reg, req_next;
    logic [4:0]           cause_reg, cause_next;
    logic [CLAIM_W-1:0]   claim_reg, claim_next;
    logic [2:0]           mip_bits_reg;    // {MEIP, MTIP, MSIP}
    logic [EXT_SRC_N-1:0] ext_act;
    logic [CLAIM_W-1:0]   claim_idx;
    logic [2:0]           pend;
    logic [4:0]           arb_cause;
    logic                 glob_en;
    logic                 frozen_pend;
    logic                 mtip_src;
    logic                 unused_sig;

    assign ext_act = ext_irq_i & ext_en_i;
    assign glob_en = mstatus_mie_i | (priv_i != PRIV_MACHINE);
    assign pend    = {mip_bits_reg[2] & mie_i[11], mip_bits_reg[1] & mie_i[7], mip_bits_reg[0] & mie_i[3]};

    always_comb begin
        claim_idx = '0;
        for (int i = EXT_SRC_N - 1; i >= 0; i--) begin
            if (ext_act[i]) claim_idx = CLAIM_W'(i);
        end
    end

    // Fixed machine-level priority: external > software > timer.
    always_comb begin
        arb_cause = CAUSE_MTI;
        if (pend[2])      arb_cause = CAUSE_MEI;
        else if (pend[0]) arb_cause = CAUSE_MSI;
    end

    always_comb begin
        case (cause_reg)
            CAUSE_MEI: frozen_pend = pend[2];
            CAUSE_MSI: frozen_pend = pend[0];
            default:   frozen_pend = pend[1];
        endcase
    end

`ifdef MTIMER_EN
    localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [TICK_W-1:0] tick_cnt_reg;
    logic [63:0]       mtime_reg;
    logic [63:0]       mtimecmp_reg;
    logic              tick;

    assign tick = (tick_cnt_reg == TICK_W'(TICK_DIV - 1));

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            tick_cnt_reg <= '0;
            mtime_reg    <= '0;
            mtimecmp_reg <= '1;
        end else begin
            tick_cnt_reg <= tick ? '0 : tick_cnt_reg + TICK_W'(1);
            if (tick) mtime_reg <= mtime_reg + 64'd1;
            if (tcmp_we_i) begin
                if (tcmp_hi_i) mtimecmp_reg[63:32] <= tcmp_data_i;
                else           mtimecmp_reg[31:0]  <= tcmp_data_i;
            end
        end
    end

    assign mtip_src   = (mtime_reg >= mtimecmp_reg);
    assign mtime_o    = mtime_reg;
    assign unused_sig = ^{mie_i[31:12], mie_i[10:8], mie_i[6:4], mie_i[2:0], timer_irq_i};
`else
    assign mtip_src   = timer_irq_i;
    assign mtime_o    = 64'd0;
    assign unused_sig = ^{mie_i[31:12], mie_i[10:8], mie_i[6:4], mie_i[2:0],
                          tcmp_we_i, tcmp_hi_i, tcmp_data_i, (TICK_DIV >= 1)};
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg    <= IDLE;
            req_reg      <= 1'b0;
            cause_reg    <= '0;
            claim_reg    <= '0;
            mip_bits_reg <= '0;
        end else begin
            state_reg    <= state_next;
            req_reg      <= req_next;
            cause_reg    <= cause_next;
            claim_reg    <= claim_next;
            mip_bits_reg <= {|ext_act, mtip_src, sw_irq_i};
        end
    end

    always_comb begin
        state_next = state_reg;
        req_next   = req_reg;
        cause_next = cause_reg;
        claim_next = claim_reg;
        case (state_reg)
            IDLE: begin
                req_next = 1'b0;
                if (glob_en && (|pend)) begin
                    state_next = REQ;
                    req_next   = 1'b1;
                    cause_next = arb_cause;
                end
            end
            REQ: begin
                // An acknowledge takes precedence over a source withdrawing in the same cycle.
                if (irq_ack_i) begin
                    state_next = TRAP;
                    req_next   = 1'b0;
                    if (cause_reg == CAUSE_MEI && (|ext_act)) claim_next = claim_idx;
                end else if (!frozen_pend || !glob_en) begin
                    state_next = IDLE;
                    req_next   = 1'b0;
                end
            end
            TRAP: begin
                req_next = 1'b0;
                if (mret_i) state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
                req_next   = 1'b0;
            end
        endcase
    end

    assign irq_req_o      = req_reg;
    assign irq_cause_o    = cause_reg;
    assign ext_claim_id_o = claim_reg;
    assign mip_o          = {20'd0, mip_bits_reg[2], 3'd0, mip_bits_reg[1], 3'd0, mip_bits_reg[0], 3'd0};

endmodule

// File: tb/tb_irq_controller.sv
// Directed self-checking bench for irq_controller: one task per scenario, inline comparisons.
module tb_irq_controller;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [7:0]  ext_irq_i;
    logic [7:0]  ext_en_i;
    logic        sw_irq_i;
    logic        timer_irq_i;
    logic        mstatus_mie_i;
    logic [31:0] mie_i;
    logic [1:0]  priv_i;
    logic        irq_ack_i;
    logic        mret_i;
    logic        tcmp_we_i;
    logic        tcmp_hi_i;
    logic [31:0] tcmp_data_i;
    logic        irq_req_o;
    logic [4:0]  irq_cause_o;
    logic [31:0] mip_o;
    logic [2:0]  ext_claim_id_o;
    logic [63:0] mtime_o;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    irq_controller #(.EXT_SRC_N(8), .TICK_DIV(1)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .ext_irq_i      (ext_irq_i),
        .ext_en_i       (ext_en_i),
        .sw_irq_i       (sw_irq_i),
        .timer_irq_i    (timer_irq_i),
        .mstatus_mie_i  (mstatus_mie_i),
        .mie_i          (mie_i),
        .priv_i         (priv_i),
        .irq_ack_i      (irq_ack_i),
        .mret_i         (mret_i),
        .tcmp_we_i      (tcmp_we_i),
        .tcmp_hi_i      (tcmp_hi_i),
        .tcmp_data_i    (tcmp_data_i),
        .irq_req_o      (irq_req_o),
        .irq_cause_o    (irq_cause_o),
        .mip_o          (mip_o),
        .ext_claim_id_o (ext_claim_id_o),
        .mtime_o        (mtime_o)
    );

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        sw_irq_i  = 1'b1;
        ext_irq_i = 8'hFF;
        reset_n   = 1'b0;
        cyc(2);
        checks++; if (irq_req_o !== 1'b0) begin failures++; $display("FAIL rst_req got=%0b exp=0", irq_req_o); end
        checks++; if (irq_cause_o !== 5'd0) begin failures++; $display("FAIL rst_cause got=%0d exp=0", irq_cause_o); end
        checks++; if (mip_o !== 32'h0) begin failures++; $display("FAIL rst_mip got=%h exp=0", mip_o); end
        checks++; if (ext_claim_id_o !== 3'd0) begin failures++; $display("FAIL rst_claim got=%0d exp=0", ext_claim_id_o); end
        checks++; if (mtime_o !== 64'd0) begin failures++; $display("FAIL rst_mtime got=%0d exp=0", mtime_o); end
        sw_irq_i  = 1'b0;
        ext_irq_i = 8'h00;
        reset_n   = 1'b1;
        cyc(2);
        checks++; if (irq_req_o !== 1'b0 || mip_o !== 32'h0) begin failures++; $display("FAIL rst_release req=%0b mip=%h exp req=0 mip=0", irq_req_o, mip_o); end
    endtask

    task automatic test_sw_request();
        sw_irq_i = 1'b1;
        cyc();
        checks++; if (mip_o !== 32'h8) begin failures++; $display("FAIL t1_mip got=%h exp=8", mip_o); end
        checks++; if (irq_req_o !== 1'b0) begin failures++; $display("FAIL t1_req_early got=%0b exp=0", irq_req_o); end
        cyc();
        checks++; if (irq_req_o !== 1'b1 || irq_cause_o !== 5'd3) begin failures++; $display("FAIL t1_req req=%0b cause=%0d exp req=1 cause=3", irq_req_o, irq_cause_o); end
        irq_ack_i = 1'b1;
        cyc();
        irq_ack_i = 1'b0;
        checks++; if (irq_req_o !== 1'b0) begin failures++; $display("FAIL t1_ack_req got=%0b exp=0", irq_req_o); end
        cyc(2);
        checks++; if (irq_req_o !== 1'b0) begin failures++; $display("FAIL t1_trap_hold got=%0b exp=0", irq_req_o); end
        checks++; if (irq_cause_o !== 5'd3) begin failures++; $display("FAIL t1_cause_held got=%0d exp=3", irq_cause_o); end
        sw_irq_i = 1'b0;
        mret_i   = 1'b1;
        cyc();
        mret_i = 1'b0;
        cyc(2);
        checks++; if (irq_req_o !== 1'b0) begin failures++; $display("FAIL t1_after_mret got=%0b exp=0", irq_req_o); end
    endtask

    task automatic test_ext_priority();
        ext_irq_i = 8'b0010_0100;
        ext_en_i  = 8'hFF;
        sw_irq_i  = 1'b1;
        cyc();
        checks++; if (mip_o !== 32'h808) begin failures++; $display("FAIL t2_mip got=%h exp=808", mip_o); end
        cyc();
        checks++; if (irq_req_o !== 1'b1 || irq_cause_o !== 5'd11) begin failures++; $display("FAIL t2_req req=%0b cause=%0d exp req=1 cause=11", irq_req_o, irq_cause_o); end
        irq_ack_i = 1'b1;
        cyc();
        irq_ack_i = 1'b0;
        checks++; if (ext_claim_id_o !== 3'd2) begin failures++; $display("FAIL t2_claim got=%0d exp=2", ext_claim_id_o); end
        ext_irq_i = 8'h00;
        sw_irq_i  = 1'b0;
        mret_i    = 1'b1;
        cyc();
        mret_i = 1'b0;
        cyc();
        // bit 7 is masked off, so the lowest enabled active line is 5
        ext_irq_i = 8'b1010_0000;
        ext_en_i  = 8'b0111_1111;
        cyc(2);
        checks++; if (irq_req_o !== 1'b1 || irq_cause_o !== 5'd11) begin failures++; $display("FAIL t2_masked_req req=%0b cause=%0d exp req=1 cause=11", irq_req_o, irq_cause_o); end
        irq_ack_i = 1'b1;
        cyc();
        irq_ack_i = 1'b0;
        checks++; if (ext_claim_id_o !== 3'd5) begin failures++; $display("FAIL t2_masked_claim got=%0d exp=5", ext_claim_id_o); end
        ext_irq_i = 8'h00;
        mret_i    = 1'b1;
        cyc();
        mret_i = 1'b0;
        ext_irq_i = 8'h01;
        ext_en_i  = 8'h00;
        cyc(2);
        checks++; if (mip_o !== 32'h0 || irq_req_o !== 1'b0) begin failures++; $display("FAIL t2_disabled mip=%h req=%0b exp mip=0 req=0", mip_o, irq_req_o); end
        ext_irq_i = 8'h00;
        ext_en_i  = 8'hFF;
        cyc();
    endtask

    task automatic test_trap_block();
        ext_irq_i = 8'h01;
        cyc(2);
        checks++; if (irq_req_o !== 1'b1 || irq_cause_o !== 5'd11) begin failures++; $display("FAIL t3_req req=%0b cause=%0d exp req=1 cause=11", irq_req_o, irq_cause_o); end
        irq_ack_i = 1'b1;
        cyc();
        irq_ack_i = 1'b0;
        checks++; if (ext_claim_id_o !== 3'd0) begin failures++; $display("FAIL t3_claim got=%0d exp=0", ext_claim_id_o); end
        ext_irq_i = 8'h00;
        sw_irq_i  = 1'b1;
        cyc(3);
        checks++; if (irq_req_o !== 1'b0) begin failures++; $display("FAIL t3_blocked got=%0b exp=0", irq_req_o); end
        mret_i = 1'b1;
        cyc();
        mret_i = 1'b0;
        checks++; if (irq_req_o !== 1'b0) begin failures++; $display("FAIL t3_mret_edge got=%0b exp=0", irq_req_o); end
        cyc();
        checks++; if (irq_req_o !== 1'b1 || irq_cause_o !== 5'd3) begin failures++; $display("FAIL t3_rearb req=%0b cause=%0d exp req=1 cause=3", irq_req_o, irq_cause_o); end
        irq_ack_i = 1'b1;
        cyc();
        irq_ack_i = 1'b0;
        sw_irq_i  = 1'b0;
        mret_i    = 1'b1;
        cyc();
        mret_i = 1'b0;
        cyc();
    endtask

    task automatic test_withdraw();
        sw_irq_i = 1'b1;
        cyc(2);
        checks++; if (irq_req_o !== 1'b1 || irq_cause_o !== 5'd3) begin failures++; $display("FAIL t4_req req=%0b cause=%0d exp req=1 cause=3", irq_req_o, irq_cause_o); end
        sw_irq_i = 1'b0;
        cyc();
        checks++; if (irq_req_o !== 1'b1) begin failures++; $display("FAIL t4_mip_lag got=%0b exp=1", irq_req_o); end
        cyc();
        checks++; if (irq_req_o !== 1'b0 || irq_cause_o !== 5'd3) begin failures++; $display("FAIL t4_withdrawn req=%0b cause=%0d exp req=0 cause=3", irq_req_o, irq_cause_o); end
        irq_ack_i = 1'b1;
        cyc();
        irq_ack_i = 1'b0;
        sw_irq_i  = 1'b1;
        cyc(2);
        checks++; if (irq_req_o !== 1'b1) begin failures++; $display("FAIL t4_stray_ack got=%0b exp=1", irq_req_o); end
        // withdraw and acknowledge in the same cycle: the acknowledge must win
        sw_irq_i = 1'b0;
        cyc();
        irq_ack_i = 1'b1;
        cyc();
        irq_ack_i = 1'b0;
        sw_irq_i  = 1'b1;
        cyc(3);
        checks++; if (irq_req_o !== 1'b0) begin failures++; $display("FAIL t4_ack_wins got=%0b exp=0", irq_req_o); end
        mret_i = 1'b1;
        cyc();
        mret_i = 1'b0;
        cyc();
        checks++; if (irq_req_o !== 1'b1) begin failures++; $display("FAIL t4_release got=%0b exp=1", irq_req_o); end
        irq_ack_i = 1'b1;
        cyc();
        irq_ack_i = 1'b0;
        sw_irq_i  = 1'b0;
        mret_i    = 1'b1;
        cyc();
        mret_i = 1'b0;
        cyc();
    endtask

    task automatic test_global_enable();
        mstatus_mie_i = 1'b0;
        priv_i        = 2'b11;
        sw_irq_i      = 1'b1;
        cyc(3);
        checks++; if (irq_req_o !== 1'b0) begin failures++; $display("FAIL t5_masked got=%0b exp=0", irq_req_o); end
        checks++; if (mip_o[3] !== 1'b1) begin failures++; $display("FAIL t5_mip got=%0b exp=1", mip_o[3]); end
        priv_i = 2'b00;
        cyc();
        checks++; if (irq_req_o !== 1'b1 || irq_cause_o !== 5'd3) begin failures++; $display("FAIL t5_user req=%0b cause=%0d exp req=1 cause=3", irq_req_o, irq_cause_o); end
        priv_i = 2'b11;
        cyc();
        checks++; if (irq_req_o !== 1'b0) begin failures++; $display("FAIL t5_en_drop got=%0b exp=0", irq_req_o); end
        mstatus_mie_i = 1'b1;
        cyc();
        checks++; if (irq_req_o !== 1'b1) begin failures++; $display("FAIL t5_mie_on got=%0b exp=1", irq_req_o); end
        irq_ack_i = 1'b1;
        cyc();
        irq_ack_i = 1'b0;
        mret_i    = 1'b1;
        cyc();
        mret_i = 1'b0;
        mie_i  = 32'h080;
        cyc(3);
        checks++; if (irq_req_o !== 1'b0) begin failures++; $display("FAIL t5_mie_mask got=%0b exp=0", irq_req_o); end
        sw_irq_i = 1'b0;
        cyc();
        mie_i = 32'h888;
        cyc();
    endtask

    task automatic test_reset_mid();
        sw_irq_i = 1'b1;
        cyc(2);
        checks++; if (irq_req_o !== 1'b1) begin failures++; $display("FAIL t7_req got=%0b exp=1", irq_req_o); end
        reset_n = 1'b0;
        cyc();
        checks++; if (irq_req_o !== 1'b0 || irq_cause_o !== 5'd0 || mip_o !== 32'h0) begin failures++; $display("FAIL t7_reset req=%0b cause=%0d mip=%h exp all 0", irq_req_o, irq_cause_o, mip_o); end
        sw_irq_i = 1'b0;
        reset_n  = 1'b1;
        cyc(2);
        checks++; if (irq_req_o !== 1'b0) begin failures++; $display("FAIL t7_after got=%0b exp=0", irq_req_o); end
    endtask

    task automatic test_timer();
`ifdef MTIMER_EN
        bit rise_seen;
        reset_n = 1'b0;
        cyc();
        reset_n     = 1'b1;
        tcmp_we_i   = 1'b1;
        tcmp_hi_i   = 1'b0;
        tcmp_data_i = 32'd20;
        cyc();
        tcmp_hi_i   = 1'b1;
        tcmp_data_i = 32'd0;
        cyc();
        tcmp_we_i = 1'b0;
        rise_seen = 1'b0;
        for (int i = 0; i < 60 && !rise_seen; i++) begin
            cyc();
            if (mip_o[7]) rise_seen = 1'b1;
        end
        checks++; if (!rise_seen) begin failures++; $display("FAIL t6_mtip_timeout mip=%h exp bit7 set within 60 cycles", mip_o); end
        checks++; if (mtime_o !== 64'd21) begin failures++; $display("FAIL t6_rise_time mtime=%0d exp=21", mtime_o); end
        checks++; if (mip_o !== 32'h80 || irq_req_o !== 1'b0) begin failures++; $display("FAIL t6_rise mip=%h req=%0b exp mip=80 req=0", mip_o, irq_req_o); end
        cyc();
        checks++; if (irq_req_o !== 1'b1 || irq_cause_o !== 5'd7) begin failures++; $display("FAIL t6_req req=%0b cause=%0d exp req=1 cause=7", irq_req_o, irq_cause_o); end
`else
        timer_irq_i = 1'b1;
        cyc();
        checks++; if (mip_o !== 32'h80) begin failures++; $display("FAIL t6_mip got=%h exp=80", mip_o); end
        cyc();
        checks++; if (irq_req_o !== 1'b1 || irq_cause_o !== 5'd7) begin failures++; $display("FAIL t6_req req=%0b cause=%0d exp req=1 cause=7", irq_req_o, irq_cause_o); end
        checks++; if (mtime_o !== 64'd0) begin failures++; $display("FAIL t6_mtime got=%0d exp=0", mtime_o); end
        irq_ack_i = 1'b1;
        cyc();
        irq_ack_i = 1'b0;
        sw_irq_i  = 1'b1;
        cyc();
        mret_i = 1'b1;
        cyc();
        mret_i = 1'b0;
        cyc();
        checks++; if (irq_req_o !== 1'b1 || irq_cause_o !== 5'd3) begin failures++; $display("FAIL t6_sw_over_timer req=%0b cause=%0d exp req=1 cause=3", irq_req_o, irq_cause_o); end
        irq_ack_i = 1'b1;
        cyc();
        irq_ack_i   = 1'b0;
        timer_irq_i = 1'b0;
        sw_irq_i    = 1'b0;
        mret_i      = 1'b1;
        cyc();
        mret_i = 1'b0;
        cyc();
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n       = 1'b0;
        ext_irq_i     = 8'h00;
        ext_en_i      = 8'hFF;
        sw_irq_i      = 1'b0;
        timer_irq_i   = 1'b0;
        mstatus_mie_i = 1'b1;
        mie_i         = 32'h888;
        priv_i        = 2'b11;
        irq_ack_i     = 1'b0;
        mret_i        = 1'b0;
        tcmp_we_i     = 1'b0;
        tcmp_hi_i     = 1'b0;
        tcmp_data_i   = 32'd0;
        cyc();
        test_reset();
        test_sw_request();
        test_ext_priority();
        test_trap_block();
        test_withdraw();
        test_global_enable();
        test_reset_mid();
        test_timer();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
